// File: rtl/bk_multiword_adder_seq.sv
// Sequential multi-word adder: one 16-bit Brent-Kung adder, LSW first, with a registered carry chain.
// Define BK_SEQ_OVF_EN to add the registered signed-overflow output out_ovf.

module brent_kung16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum,
    input  logic        cin,
    output logic        carry
);
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] gg;
    logic [15:0] pg;

    always_comb begin
        g  = a & b;
        p  = a ^ b;
        gg = g;
        pg = p;
        // Fold cin into bit 0 so every prefix gg[i] is the carry out of bit i.
        gg[0] = g[0] | (p[0] & cin);
        for (int l = 0; l < 4; l++) begin
            for (int i = 0; i < 16; i++) begin
                if (((i + 1) % (2 << l)) == 0) begin
                    gg[i] = gg[i] | (pg[i] & gg[i - (1 << l)]);
                    pg[i] = pg[i] & pg[i - (1 << l)];
                end
            end
        end
        for (int l = 2; l >= 0; l--) begin
            for (int i = 0; i < 16; i++) begin
                if ((i >= (3 << l) - 1) && (((i + 1) % (2 << l)) == (1 << l))) begin
                    gg[i] = gg[i] | (pg[i] & gg[i - (1 << l)]);
                    pg[i] = pg[i] & pg[i - (1 << l)];
                end
            end
        end
        sum[0] = p[0] ^ cin;
        for (int i = 1; i < 16; i++) begin
            sum[i] = p[i] ^ gg[i - 1];
        end
        carry = gg[15];
    end
endmodule

module bk_multiword_adder_seq #(
    parameter int unsigned WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [16*WORDS-1:0]   in_a,
    input  logic [16*WORDS-1:0]   in_b,
    input  logic                  in_cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [16*WORDS-1:0]   out_sum,
    output logic                  out_cout,
    output logic                  busy
`ifdef BK_SEQ_OVF_EN
    ,
    output logic                  out_ovf
`endif
);
    localparam int unsigned W  = 16 * WORDS;
    localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    op_a_q, op_a_d;
    logic [W-1:0]    op_b_q, op_b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            carry_q, carry_d;
    logic [IW-1:0]   idx_q, idx_d;

    logic [15:0]     word_a;
    logic [15:0]     word_b;
    logic [15:0]     word_sum;
    logic            word_cout;
    logic            last_word;

    assign word_a    = op_a_q[16*idx_q +: 16];
    assign word_b    = op_b_q[16*idx_q +: 16];
    assign last_word = (idx_q == IW'(WORDS - 1));

    brent_kung16bit u_adder (
        .a     (word_a),
        .b     (word_b),
        .sum   (word_sum),
        .cin   (carry_q),
        .carry (word_cout)
    );

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    op_a_d  = in_a;
                    op_b_d  = in_b;
                    carry_d = in_cin;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d[16*idx_q +: 16] = word_sum;
                carry_d               = word_cout;
                if (last_word) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
        end
    end

`ifdef BK_SEQ_OVF_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (state_q == StRun && last_word) begin
            ovf_d = (op_a_q[W-1] == op_b_q[W-1]) && (word_sum[15] != op_a_q[W-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign out_ovf = ovf_q;
`endif

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign out_sum   = sum_q;
    assign out_cout  = carry_q;
endmodule
